// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: consumes one packed BCD digit per clock, LSD first,
// and publishes sum/cout/invalid together with a one-cycle done pulse.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_acc;
    logic               r_inv;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_invalid;

    logic               w_latch;
    logic               w_last;
    logic [4:0]         w_raw;
    logic               w_fix;
    logic [3:0]         w_digit;
    logic               w_digit_bad;
    logic [W+3:0]       w_acc_cat;
    logic [W-1:0]       w_acc_next;
    logic               w_inv_next;

    // start is only honoured when no operation is in flight.
    assign w_latch = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last  = (r_idx == IDX_W'(DIGITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first guarantees every path drives the
    // next state, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_ADD;
            S_ADD:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_ADD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operands shift right each cycle, so the active digit is always [3:0].
    assign w_raw       = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
    assign w_fix       = (w_raw > 5'd9);
    assign w_digit     = w_fix ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
    assign w_digit_bad = (r_a[3:0] > 4'd9) || (r_b[3:0] > 4'd9);
    assign w_inv_next  = r_inv | w_digit_bad;

    // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0].
    assign w_acc_cat   = {w_digit, r_acc};
    assign w_acc_next  = w_acc_cat[W+3:4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_inv     <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else if (w_latch) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_acc   <= '0;
            r_inv   <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_fix;
            r_idx   <= r_idx + IDX_W'(1);
            r_acc   <= w_acc_next;
            r_inv   <= w_inv_next;
            if (w_last) begin
                r_sum     <= w_acc_next;
                r_cout    <= w_fix;
                r_invalid <= w_inv_next;
            end
        end
    end

    assign busy    = (r_state == S_ADD);
    assign done    = (r_state == S_DONE);
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign invalid = r_invalid;

endmodule
